cla_adder_pipe: RTL and testbench



---
 rtl/cla_pkg.sv | 38 +++
 rtl/cla_group.sv | 38 +++
 rtl/cla_adder_pipe.sv | 135 +++++++++++++
 tb/tb_cla_adder_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: default geometry,
// segment/group sizing helpers and the group propagate/generate reduction.
package cla_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_GRP_W       = 4;
    localparam int DEF_PIPE_STAGES = 2;
    localparam int MAX_PG_W        = 64;

    function automatic int seg_w(input int data_w, input int stages);
        return data_w / stages;
    endfunction

    function automatic int grp_n(input int seg, input int grp);
        return seg / grp;
    endfunction

    localparam int SEG_W = seg_w(DEF_DATA_W, DEF_PIPE_STAGES);
    localparam int GRP_N = grp_n(SEG_W, DEF_GRP_W);

    // Reduces n bit-level (p, g) pairs, LSB first, into one group {P, G}.
    function automatic logic [1:0] group_pg(input logic [MAX_PG_W-1:0] p,
                                            input logic [MAX_PG_W-1:0] g,
                                            input int n);
        logic pp;
        logic gg;
        pp = 1'b1;
        gg = 1'b0;
        for (int i = 0; i < MAX_PG_W; i++) begin
            if (i < n) begin
                gg = g[i] | (p[i] & gg);
                pp = pp & p[i];
            end
        end
        return {pp, gg};
    endfunction

endpackage

// File: rtl/cla_group.sv
// GRP_W-bit lookahead group: local sum bits from a group carry-in, plus the
// group propagate/generate used by the segment-level lookahead.
module cla_group
    import cla_pkg::*;
#(
    parameter int GRP_W = 4
) (
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             c_in,
    output logic [GRP_W-1:0] s,
    output logic             p,
    output logic             g
);

    logic [GRP_W-1:0] pb;
    logic [GRP_W-1:0] gb;
    logic [GRP_W-1:0] c;
    logic [1:0]       pg;

    assign pb = a ^ b;
    assign gb = a & b;

    // P/G depend on the operands only, never on c_in.
    assign pg = group_pg(MAX_PG_W'(pb), MAX_PG_W'(gb), GRP_W);
    assign p  = pg[1];
    assign g  = pg[0];

    always_comb begin
        c[0] = c_in;
        for (int i = 0; i < GRP_W - 1; i++) begin
            c[i+1] = gb[i] | (pb[i] & c[i]);
        end
    end

    assign s = pb ^ c;

endmodule

// File: rtl/cla_adder_pipe.sv
// Skewed-pipeline carry-lookahead adder/subtractor with valid/ready flow control;
// stage k resolves segment k and forwards its carry with the unprocessed operand bits.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int GRP_W       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] dinb,
    input  logic              cin,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              overflow,
    output logic              zero
);

    if (GRP_W < 1 || GRP_W > MAX_PG_W || PIPE_STAGES < 1 ||
        PIPE_STAGES > DATA_W / GRP_W || (DATA_W % (PIPE_STAGES * GRP_W)) != 0) begin : g_bad_param
        $error("cla_adder_pipe: illegal DATA_W/GRP_W/PIPE_STAGES combination");
    end

    localparam int SW = seg_w(DATA_W, PIPE_STAGES);
    localparam int GN = grp_n(SW, GRP_W);

    // a_rem/b_rem hold the not-yet-processed operand bits shifted down to bit 0;
    // psum collects finished segments from the top so the last stage is aligned.
    typedef struct packed {
        logic              carry;
        logic [DATA_W-1:0] a_rem;
        logic [DATA_W-1:0] b_rem;
        logic [DATA_W-1:0] psum;
    } pl_t;

    logic [PIPE_STAGES:0]   rdy;
    logic [PIPE_STAGES-1:0] vld;
    pl_t                    pl [PIPE_STAGES];
    logic                   ovf_r;
    logic                   zero_r;

    assign rdy[PIPE_STAGES] = out_ready;
    assign in_ready         = rdy[0];

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        logic          vin;
        pl_t           pin;
        pl_t           pnx;
        logic [SW-1:0] sa;
        logic [SW-1:0] sb;
        logic [SW-1:0] ss;
        logic [GN:0]   gc;
        logic [GN-1:0] gp;
        logic [GN-1:0] gg;

        if (k == 0) begin : g_head
            assign vin       = in_valid;
            assign pin.carry = sub ? ~cin : cin;
            assign pin.a_rem = dina;
            assign pin.b_rem = sub ? ~dinb : dinb;
            assign pin.psum  = '0;
        end else begin : g_body
            assign vin = vld[k-1];
            assign pin = pl[k-1];
        end

        assign sa = pin.a_rem[SW-1:0];
        assign sb = pin.b_rem[SW-1:0];

        for (genvar j = 0; j < GN; j++) begin : g_grp
            cla_group #(.GRP_W(GRP_W)) u_grp (
                .a    (sa[j*GRP_W +: GRP_W]),
                .b    (sb[j*GRP_W +: GRP_W]),
                .c_in (gc[j]),
                .s    (ss[j*GRP_W +: GRP_W]),
                .p    (gp[j]),
                .g    (gg[j])
            );
        end

        always_comb begin
            gc[0] = pin.carry;
            for (int j = 0; j < GN; j++) begin
                gc[j+1] = gg[j] | (gp[j] & gc[j]);
            end
        end

        always_comb begin
            pnx.carry = gc[GN];
            pnx.a_rem = pin.a_rem >> SW;
            pnx.b_rem = pin.b_rem >> SW;
            pnx.psum  = (pin.psum >> SW) | (DATA_W'(ss) << (DATA_W - SW));
        end

        assign rdy[k] = !vld[k] || rdy[k+1];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld[k] <= 1'b0;
                pl[k]  <= '0;
            end else if (rdy[k]) begin
                vld[k] <= vin;
                if (vin) begin
                    pl[k] <= pnx;
                end
            end
        end

        if (k == PIPE_STAGES - 1) begin : g_tail
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (rdy[k] && vin) begin
                    ovf_r  <= (sa[SW-1] == sb[SW-1]) && (ss[SW-1] != sa[SW-1]);
                    zero_r <= (pnx.psum == '0);
                end
            end
        end
    end

    assign out_valid = vld[PIPE_STAGES-1];
    assign sum       = pl[PIPE_STAGES-1].psum;
    assign cout      = pl[PIPE_STAGES-1].carry;
    assign overflow  = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: five configurations share one stimulus stream and are
// checked against an arithmetic reference model.
module tb_cla_adder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] dina = '0;
    logic [63:0] dinb = '0;

    logic [4:0]  irdy;
    logic [4:0]  ovld;
    logic [4:0]  co;
    logic [4:0]  of;
    logic [4:0]  zr;
    logic [31:0] sum0, sum1, sum2, sum3;
    logic [63:0] sum4;
    logic [63:0] sm [5];

    int n_chk  = 0;
    int n_fail = 0;

    localparam int LAT [5] = '{2, 1, 4, 8, 4};
    localparam int WID [5] = '{32, 32, 32, 32, 64};

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        s;
        logic [31:0] es;
        logic        ec;
        logic        eo;
        logic        ez;
    } dcase_t;

    always #5 clk = ~clk;

    always_comb begin
        sm[0] = {32'd0, sum0};
        sm[1] = {32'd0, sum1};
        sm[2] = {32'd0, sum2};
        sm[3] = {32'd0, sum3};
        sm[4] = sum4;
    end

    cla_adder_pipe #(.DATA_W(32), .GRP_W(4), .PIPE_STAGES(2)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]),
        .dina(dina[31:0]), .dinb(dinb[31:0]), .cin(cin), .sub(sub),
        .out_valid(ovld[0]), .out_ready(out_ready), .sum(sum0),
        .cout(co[0]), .overflow(of[0]), .zero(zr[0]));

    cla_adder_pipe #(.DATA_W(32), .GRP_W(4), .PIPE_STAGES(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]),
        .dina(dina[31:0]), .dinb(dinb[31:0]), .cin(cin), .sub(sub),
        .out_valid(ovld[1]), .out_ready(out_ready), .sum(sum1),
        .cout(co[1]), .overflow(of[1]), .zero(zr[1]));

    cla_adder_pipe #(.DATA_W(32), .GRP_W(4), .PIPE_STAGES(4)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]),
        .dina(dina[31:0]), .dinb(dinb[31:0]), .cin(cin), .sub(sub),
        .out_valid(ovld[2]), .out_ready(out_ready), .sum(sum2),
        .cout(co[2]), .overflow(of[2]), .zero(zr[2]));

    cla_adder_pipe #(.DATA_W(32), .GRP_W(4), .PIPE_STAGES(8)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[3]),
        .dina(dina[31:0]), .dinb(dinb[31:0]), .cin(cin), .sub(sub),
        .out_valid(ovld[3]), .out_ready(out_ready), .sum(sum3),
        .cout(co[3]), .overflow(of[3]), .zero(zr[3]));

    cla_adder_pipe #(.DATA_W(64), .GRP_W(4), .PIPE_STAGES(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[4]),
        .dina(dina), .dinb(dinb), .cin(cin), .sub(sub),
        .out_valid(ovld[4]), .out_ready(out_ready), .sum(sum4),
        .cout(co[4]), .overflow(of[4]), .zero(zr[4]));

    // Integer arithmetic on wide signed values; no bit-level carry logic.
    function automatic res_t model(input logic [63:0] a_in, input logic [63:0] b_in,
                                   input logic ci, input logic s, input int w);
        logic [63:0]        mask, a, b;
        logic signed [67:0] ua, ub, sa, sb, cs, u, r, lim;
        res_t               res;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a    = a_in & mask;
        b    = b_in & mask;
        ua   = $signed({4'd0, a});
        ub   = $signed({4'd0, b});
        cs   = $signed({67'd0, ci});
        sa   = a[w-1] ? ua - (68'sd1 <<< w) : ua;
        sb   = b[w-1] ? ub - (68'sd1 <<< w) : ub;
        lim  = 68'sd1 <<< (w - 1);
        u    = s ? (ua - ub - cs) : (ua + ub + cs);
        r    = s ? (sa - sb - cs) : (sa + sb + cs);
        res.s = u[63:0] & mask;
        res.c = s ? (u >= 68'sd0) : u[w];
        res.o = (r >= lim) || (r < -lim);
        res.z = (res.s == 64'd0);
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if ({ovld[i], sm[i], co[i], of[i], zr[i]} !== 68'd0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got v=%b s=%h c=%b o=%b z=%b, want all 0",
                         i, ovld[i], sm[i], co[i], of[i], zr[i]);
            end
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (irdy !== 5'h1f) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, want 11111", irdy);
        end
        tick();
    endtask

    task automatic test_directed();
        dcase_t tbl [7] = '{
            '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
            '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
            '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0},
            '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
            '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0},
            '{32'hFFFF_FFFE, 32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0},
            '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0}
        };
        for (int t = 0; t < 7; t++) begin
            int   lat [5];
            res_t cap [5];
            res_t exp64;
            dina = {32'd0, tbl[t].a}; dinb = {32'd0, tbl[t].b};
            cin = tbl[t].ci; sub = tbl[t].s;
            in_valid = 1'b1; out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int i = 0; i < 5; i++) begin
                lat[i] = 0;
                cap[i] = '0;
            end
            for (int n = 1; n <= 20; n++) begin
                for (int i = 0; i < 5; i++) begin
                    if (lat[i] == 0 && ovld[i]) begin
                        lat[i] = n;
                        cap[i] = '{s: sm[i], c: co[i], o: of[i], z: zr[i]};
                    end
                end
                tick();
            end
            exp64 = model({32'd0, tbl[t].a}, {32'd0, tbl[t].b}, tbl[t].ci, tbl[t].s, 64);
            for (int i = 0; i < 5; i++) begin
                res_t want;
                want = (i < 4) ? '{s: {32'd0, tbl[t].es}, c: tbl[t].ec, o: tbl[t].eo, z: tbl[t].ez}
                               : exp64;
                n_chk++;
                if (lat[i] != LAT[i]) begin
                    n_fail++;
                    $display("FAIL latency case%0d dut%0d: got %0d cycles, want %0d", t, i, lat[i], LAT[i]);
                end
                n_chk++;
                if (cap[i] !== want) begin
                    n_fail++;
                    $display("FAIL directed case%0d dut%0d: got s=%h c=%b o=%b z=%b, want s=%h c=%b o=%b z=%b",
                             t, i, cap[i].s, cap[i].c, cap[i].o, cap[i].z, want.s, want.c, want.o, want.z);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ba [6];
        logic [31:0] bb [6];
        logic        bc [6];
        logic        bs [6];
        int idx  = 0;
        int head = 0;
        for (int i = 0; i < 6; i++) begin
            ba[i] = $urandom; bb[i] = $urandom;
            bc[i] = 1'($urandom_range(0, 1)); bs[i] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 60; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            in_valid  = (idx < 6);
            if (idx < 6) begin
                dina = {32'd0, ba[idx]}; dinb = {32'd0, bb[idx]};
                cin = bc[idx]; sub = bs[idx];
            end
            #1;
            if (c == 3) begin
                n_chk++;
                if (irdy[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready: got %b, want 0 with two beats held", irdy[0]);
                end
            end
            if (ovld[0]) begin
                n_chk++;
                if (head >= 6) begin
                    n_fail++;
                    $display("FAIL b2b_extra_output: got beat beyond 6, want none");
                end else begin
                    res_t want;
                    want = model({32'd0, ba[head]}, {32'd0, bb[head]}, bc[head], bs[head], 32);
                    if ({sm[0], co[0], of[0], zr[0]} !== want) begin
                        n_fail++;
                        $display("FAIL b2b_beat%0d: got s=%h c=%b o=%b z=%b, want s=%h c=%b o=%b z=%b",
                                 head, sm[0], co[0], of[0], zr[0], want.s, want.c, want.o, want.z);
                    end
                end
                if (out_ready) head++;
            end
            if (in_valid && irdy[0]) idx++;
            if (head == 6 && idx == 6) break;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_chk++;
        if (head != 6) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results, want 6", head);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [4:0] stale = '0;
        out_ready = 1'b1;
        dina = 64'h1234_5678_9ABC_DEF0; dinb = 64'h0F0F_0F0F_0F0F_0F0F; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        tick();
        dina = 64'hFFFF_FFFF_FFFF_FFFF; dinb = 64'd1;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if ({ovld[i], sm[i], co[i], of[i], zr[i]} !== 68'd0 || irdy[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL midflight_reset dut%0d: got v=%b s=%h c=%b o=%b z=%b rdy=%b, want zeros rdy=1",
                         i, ovld[i], sm[i], co[i], of[i], zr[i], irdy[i]);
            end
        end
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            stale |= ovld;
        end
        n_chk++;
        if (stale !== 5'd0) begin
            n_fail++;
            $display("FAIL stale_after_reset: got out_valid seen %b, want 00000", stale);
        end
    endtask

    task automatic test_random();
        logic        hv [16];
        logic [63:0] ha [16];
        logic [63:0] hb [16];
        logic        hc [16];
        logic        hs [16];
        for (int i = 0; i < 16; i++) begin
            hv[i] = 1'b0; ha[i] = '0; hb[i] = '0; hc[i] = 1'b0; hs[i] = 1'b0;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            int mode;
            n_chk++;
            if (irdy !== 5'h1f) begin
                n_fail++;
                $display("FAIL rand_in_ready cyc%0d: got %b, want 11111", c, irdy);
            end
            for (int i = 0; i < 5; i++) begin
                int k;
                k = (c - LAT[i] + 16) % 16;
                n_chk++;
                if (ovld[i] !== hv[k]) begin
                    n_fail++;
                    $display("FAIL rand_valid cyc%0d dut%0d: got %b, want %b", c, i, ovld[i], hv[k]);
                end else if (hv[k]) begin
                    res_t want;
                    want = model(ha[k], hb[k], hc[k], hs[k], WID[i]);
                    if ({sm[i], co[i], of[i], zr[i]} !== want) begin
                        n_fail++;
                        $display("FAIL rand_result cyc%0d dut%0d: got s=%h c=%b o=%b z=%b, want s=%h c=%b o=%b z=%b",
                                 c, i, sm[i], co[i], of[i], zr[i], want.s, want.c, want.o, want.z);
                    end
                end
            end
            mode = $urandom_range(0, 7);
            dina = {$urandom, $urandom};
            dinb = {$urandom, $urandom};
            if (mode == 0) dina = '1;
            if (mode == 1) dinb = ~dina;
            if (mode == 2) dinb = dina;
            if (mode == 3) dina = {$urandom, 32'h7FFF_FFFF};
            cin      = 1'($urandom_range(0, 1));
            sub      = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 9) < 8);
            hv[c % 16] = in_valid; ha[c % 16] = dina; hb[c % 16] = dinb;
            hc[c % 16] = cin;      hs[c % 16] = sub;
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
